// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of the PicoSoC UART data register
// among NREQ byte-stream requesters, with an idle timeout that releases a stalled lock.
module uart_tx_arbiter #(
   parameter int NREQ = 4,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   grant,
   output logic              uart_dat_we,
   output logic [31:0]       uart_dat_di,
   input  logic              uart_dat_wait,
   output logic              timeout_evt
);
   localparam int PW = $clog2(NREQ);
   localparam int CW = LOCK_TIMEOUT > 0 ? $clog2(LOCK_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT > 0 ? LOCK_TIMEOUT - 1 : 0);
   typedef enum logic [1:0] {IDLE, SEND, LOCKED} state_t;
   state_t state;
   logic [PW-1:0] rr, owner, win, sel;
   logic [7:0] hold, sel_data;
   logic hold_last, any_valid, own_valid;
   logic [CW-1:0] cnt;
   int idx;
   // Lowest rotation distance from rr+1 wins, so scan from farthest to nearest.
   always_comb begin
      win = '0;
      idx = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(rr) + 1 + k) % NREQ;
         if (req_valid[PW'(idx)]) win = PW'(idx);
      end
   end
   assign any_valid = |req_valid;
   assign own_valid = req_valid[owner];
   assign sel = state == LOCKED ? owner : win;
   assign sel_data = req_data[{sel, 3'b000} +: 8];
   assign req_ready = !resetn ? '0 :
                      state == IDLE ? (any_valid ? NREQ'(1) << win : '0) :
                      state == LOCKED ? grant & req_valid : '0;
   assign uart_dat_di = {24'h0, uart_dat_we ? hold : 8'h0};
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         grant <= '0;
         uart_dat_we <= 1'b0;
         timeout_evt <= 1'b0;
         hold <= '0;
         hold_last <= 1'b0;
         cnt <= '0;
         owner <= '0;
         rr <= PW'(NREQ - 1);
      end else begin
         timeout_evt <= 1'b0;
         case (state)
            IDLE: if (any_valid) begin
               hold <= sel_data;
               hold_last <= req_last[win];
               owner <= win;
               grant <= NREQ'(1) << win;
               uart_dat_we <= 1'b1;
               state <= SEND;
            end
            SEND: if (!uart_dat_wait) begin
               uart_dat_we <= 1'b0;
               cnt <= '0;
               if (hold_last) begin
                  rr <= owner;
                  grant <= '0;
                  state <= IDLE;
               end else state <= LOCKED;
            end
            LOCKED: if (own_valid) begin
               hold <= sel_data;
               hold_last <= req_last[owner];
               cnt <= '0;
               uart_dat_we <= 1'b1;
               state <= SEND;
            end else if (LOCK_TIMEOUT != 0 && cnt == TO_LAST) begin
               timeout_evt <= 1'b1;
               rr <= owner;
               grant <= '0;
               state <= IDLE;
            end else if (cnt != '1) cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: per-requester byte feeders, scoreboard of expected UART writes
// checked by an independent monitor, plus directed checks of ready/grant/timeout timing.
module tb_uart_tx_arbiter;
   logic clk = 0, resetn = 0, uart_dat_wait = 0;
   logic [3:0] req_valid = 0, req_last = 0, req_ready, grant, acc = 0;
   logic [31:0] req_data = 0, uart_dat_di;
   logic uart_dat_we, timeout_evt;
   logic [8:0] fifo [4][16];
   int head [4] = '{0, 0, 0, 0};
   int tail [4] = '{0, 0, 0, 0};
   logic [35:0] sb [$];
   logic [35:0] e;
   int checks = 0, errors = 0, writes = 0, w0 = 0;

   uart_tx_arbiter #(.NREQ(4), .LOCK_TIMEOUT(8)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .grant(grant),
      .uart_dat_we(uart_dat_we), .uart_dat_di(uart_dat_di),
      .uart_dat_wait(uart_dat_wait), .timeout_evt(timeout_evt));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int r, input logic last, input logic [7:0] d, input logic exp_write);
      fifo[r][tail[r] % 16] = {last, d};
      tail[r]++;
      if (exp_write) sb.push_back({4'(1 << r), 24'h0, d});
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic at_pos();
      @(posedge clk);
      #2;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d writes still expected after %0d cycles", sb.size(), n);
      end
   endtask

   // Requester model: holds each byte on valid until the handshake is observed.
   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (acc[i] && head[i] != tail[i]) head[i]++;
         req_valid[i] = head[i] != tail[i];
         req_data[8*i +: 8] = fifo[i][head[i] % 16][7:0];
         req_last[i] = fifo[i][head[i] % 16][8];
      end
   end

   initial forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (resetn && uart_dat_we && !uart_dat_wait) begin
         writes++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL uart_write: unexpected write %h grant %b", uart_dat_di, grant);
         end else begin
            e = sb.pop_front();
            if ({grant, uart_dat_di} !== e) begin
               errors++;
               $display("FAIL uart_write: got grant %b di %h expected grant %b di %h",
                        grant, uart_dat_di, e[35:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 16; j++) fifo[i][j] = '0;
      repeat (3) at_neg();
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_we", 32'(uart_dat_we), 0);
      chk("rst_di", uart_dat_di, 0);
      chk("rst_tevt", 32'(timeout_evt), 0);
      at_pos();
      resetn = 1;
      // single byte packet
      at_neg();
      push(0, 1, 8'h41, 1);
      at_neg();
      chk("t1_ready", 32'(req_ready), 32'h1);
      at_neg();
      chk("t1_we", 32'(uart_dat_we), 1);
      chk("t1_di", uart_dat_di, 32'h41);
      at_neg();
      chk("t1_we_off", 32'(uart_dat_we), 0);
      chk("t1_grant_off", 32'(grant), 0);
      // round robin, rotation continues after requester 0
      at_neg();
      for (int i = 0; i < 4; i++) begin
         push(i, 1, 8'hA0 + 8'(i), 0);
         push(i, 1, 8'hB0 + 8'(i), 0);
      end
      sb.push_back({4'b0010, 32'hA1}); sb.push_back({4'b0100, 32'hA2});
      sb.push_back({4'b1000, 32'hA3}); sb.push_back({4'b0001, 32'hA0});
      sb.push_back({4'b0010, 32'hB1}); sb.push_back({4'b0100, 32'hB2});
      sb.push_back({4'b1000, 32'hB3}); sb.push_back({4'b0001, 32'hB0});
      drain();
      // packet lock: requester 2 keeps the grant while requester 1 waits
      at_neg();
      push(2, 0, 8'hC0, 1);
      push(2, 0, 8'hC1, 1);
      push(2, 1, 8'hC2, 1);
      at_neg();
      chk("t3_ready", 32'(req_ready), 32'h4);
      push(1, 1, 8'hD1, 1);
      for (int k = 1; k <= 5; k++) begin
         at_neg();
         chk("t3_lock_ready1", 32'(req_ready[1]), 0);
         chk("t3_lock_grant", 32'(grant), 32'h4);
      end
      drain();
      // wait stretching
      at_pos();
      uart_dat_wait = 1;
      at_neg();
      push(3, 1, 8'hE3, 1);
      at_neg();
      chk("t4_ready", 32'(req_ready), 32'h8);
      push(0, 1, 8'hE0, 1);
      w0 = writes;
      for (int k = 1; k <= 20; k++) begin
         at_neg();
         chk("t4_we", 32'(uart_dat_we), 1);
         chk("t4_di", uart_dat_di, 32'hE3);
         chk("t4_ready_held", 32'(req_ready), 0);
      end
      at_pos();
      uart_dat_wait = 0;
      at_neg();
      chk("t4_we_last", 32'(uart_dat_we), 1);
      chk("t4_di_last", uart_dat_di, 32'hE3);
      at_neg();
      chk("t4_one_write", writes, w0 + 1);
      chk("t4_next_ready", 32'(req_ready), 32'h1);
      drain();
      // lock timeout: requester 0 stalls mid-packet, requester 3 waits
      at_neg();
      push(0, 0, 8'hF0, 1);
      at_neg();
      chk("t5_ready", 32'(req_ready), 32'h1);
      push(3, 1, 8'hF3, 1);
      for (int k = 1; k <= 12; k++) begin
         at_neg();
         chk("t5_tevt", 32'(timeout_evt), 32'(k == 10));
         if (k >= 2 && k <= 9) chk("t5_locked_ready", 32'(req_ready), 0);
         if (k == 10) begin
            chk("t5_release_ready", 32'(req_ready), 32'h8);
            chk("t5_release_grant", 32'(grant), 0);
         end
      end
      drain();
      // asynchronous reset in the middle of a stretched write
      at_pos();
      uart_dat_wait = 1;
      at_neg();
      push(1, 1, 8'h77, 1);
      at_neg();
      chk("t6_ready", 32'(req_ready), 32'h2);
      push(0, 1, 8'h55, 0);
      at_neg();
      chk("t6_we_before", 32'(uart_dat_we), 1);
      #3;
      resetn = 0;
      #1;
      chk("t6_we_rst", 32'(uart_dat_we), 0);
      chk("t6_grant_rst", 32'(grant), 0);
      chk("t6_ready_rst", 32'(req_ready), 0);
      chk("t6_di_rst", uart_dat_di, 0);
      sb.delete();
      for (int i = 0; i < 4; i++) head[i] = tail[i];
      uart_dat_wait = 0;
      for (int i = 0; i < 4; i++) push(i, 1, 8'h10 + 8'(i), 1);
      at_pos();
      resetn = 1;
      at_neg();
      chk("t6_first_prio", 32'(req_ready), 32'h1);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
